snake_body_engine: RTL and testbench

Parametrised snake movement engine for the board grid: holds up to MAX_LEN body segments, advances the snake one cell per accepted `step`, supports growth, rejects 180° reversals and detects wall or self collision. It replaces the stand-alone next-head calculator between the input/tick controller and the renderer/GUI bridge. The renderer reads any segment through a random-access read port.

---
 rtl/snake_body_engine_if.sv | 33 +++
 rtl/snake_body_engine.sv | 216 +++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_body_engine_if.sv
// rtl/snake_body_engine_if.sv - step/status/read-port bundle between controller, engine and renderer
interface snake_body_engine_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int LEN_WIDTH  = 6
) ();

  logic                  step_i;
  logic [1:0]            direction_i;
  logic                  grow_i;
  logic                  busy_o;
  logic                  step_done_o;
  logic                  alive_o;
  logic [ADDR_WIDTH-1:0] head_x_o;
  logic [ADDR_WIDTH-1:0] head_y_o;
  logic [LEN_WIDTH-1:0]  length_o;
  logic [LEN_WIDTH-1:0]  rd_idx_i;
  logic [ADDR_WIDTH-1:0] rd_x_o;
  logic [ADDR_WIDTH-1:0] rd_y_o;
  logic                  rd_valid_o;

  modport master (
    output step_i, direction_i, grow_i, rd_idx_i,
    input  busy_o, step_done_o, alive_o, head_x_o, head_y_o, length_o,
           rd_x_o, rd_y_o, rd_valid_o
  );

  modport slave (
    input  step_i, direction_i, grow_i, rd_idx_i,
    output busy_o, step_done_o, alive_o, head_x_o, head_y_o, length_o,
           rd_x_o, rd_y_o, rd_valid_o
  );

endinterface

// File: rtl/snake_body_engine.sv
// rtl/snake_body_engine.sv - snake body storage, movement, growth and collision engine
module snake_body_engine #(
  parameter int BOARD_WIDTH  = 20,
  parameter int BOARD_HEIGHT = 20,
  parameter int ADDR_WIDTH   = 5,
  parameter int MAX_LEN      = 32,
  parameter int LEN_WIDTH    = 6,
  parameter int INIT_LEN     = 3,
  parameter int WRAP         = 1
) (
  input  logic clk,
  input  logic reset_n,
  snake_body_engine_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_MOVE, S_DEAD} state_t;

  localparam logic [1:0] DIR_N = 2'b00;
  localparam logic [1:0] DIR_E = 2'b01;
  localparam logic [1:0] DIR_S = 2'b10;
  localparam logic [1:0] DIR_W = 2'b11;

  localparam logic [ADDR_WIDTH:0]  BW_C    = (ADDR_WIDTH+1)'(BOARD_WIDTH);
  localparam logic [ADDR_WIDTH:0]  BH_C    = (ADDR_WIDTH+1)'(BOARD_HEIGHT);
  localparam logic [ADDR_WIDTH:0]  ONES_C  = '1;
  localparam logic [ADDR_WIDTH:0]  ONE_A_C = (ADDR_WIDTH+1)'(1);
  localparam logic [LEN_WIDTH-1:0] MAX_C   = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] ONE_L_C = LEN_WIDTH'(1);

  state_t                state_q, state_d;
  logic [1:0]            dir_q, dir_d;
  logic                  grow_q, grow_d;
  logic [ADDR_WIDTH-1:0] cand_x_q, cand_x_d;
  logic [ADDR_WIDTH-1:0] cand_y_q, cand_y_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [LEN_WIDTH-1:0]  last_q, last_d;
  logic [LEN_WIDTH-1:0]  length_q, length_d;
  logic                  step_done_q, step_done_d;

  logic [ADDR_WIDTH-1:0] seg_x_q [MAX_LEN];
  logic [ADDR_WIDTH-1:0] seg_y_q [MAX_LEN];

  logic [1:0]            dir_new;
  logic [ADDR_WIDTH:0]   nx, ny;
  logic                  oob;
  logic                  grow_eff;
  logic [LEN_WIDTH-1:0]  cmp_cnt;
  logic                  hit;
  logic                  rd_ok;
  logic [ADDR_WIDTH-1:0] rd_x, rd_y;

  // Candidate head for a step requested now: reversal filter, extended-width move, edge handling
  always_comb begin
    dir_new = (bus.direction_i == (dir_q ^ 2'b10)) ? dir_q : bus.direction_i;
    nx      = {1'b0, seg_x_q[0]};
    ny      = {1'b0, seg_y_q[0]};
    oob     = 1'b0;
    case (dir_new)
      DIR_N:   ny = ny - ONE_A_C;
      DIR_E:   nx = nx + ONE_A_C;
      DIR_S:   ny = ny + ONE_A_C;
      default: nx = nx - ONE_A_C;
    endcase
    if (nx == BW_C) begin
      oob = 1'b1;
      nx  = '0;
    end else if (nx == ONES_C) begin
      oob = 1'b1;
      nx  = BW_C - ONE_A_C;
    end
    if (ny == BH_C) begin
      oob = 1'b1;
      ny  = '0;
    end else if (ny == ONES_C) begin
      oob = 1'b1;
      ny  = BH_C - ONE_A_C;
    end
    grow_eff = bus.grow_i && (length_q < MAX_C);
    // Without growth the tail leaves its cell on this move, so it is not compared
    cmp_cnt  = grow_eff ? length_q : (length_q - ONE_L_C);
  end

  // Self-collision compare of the latched candidate against the segment at idx_q
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx_q == LEN_WIDTH'(i) && seg_x_q[i] == cand_x_q && seg_y_q[i] == cand_y_q) begin
        hit = 1'b1;
      end
    end
  end

  // Renderer read port, zero outside the live body
  always_comb begin
    rd_ok = bus.rd_idx_i < length_q;
    rd_x  = '0;
    rd_y  = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (rd_ok && bus.rd_idx_i == LEN_WIDTH'(i)) begin
        rd_x = seg_x_q[i];
        rd_y = seg_y_q[i];
      end
    end
  end

  // Step FSM: next state, latched step context and completion pulse
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    grow_d      = grow_q;
    cand_x_d    = cand_x_q;
    cand_y_d    = cand_y_q;
    idx_d       = idx_q;
    last_d      = last_q;
    length_d    = length_q;
    step_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.step_i) begin
          dir_d    = dir_new;
          grow_d   = grow_eff;
          cand_x_d = nx[ADDR_WIDTH-1:0];
          cand_y_d = ny[ADDR_WIDTH-1:0];
          idx_d    = '0;
          last_d   = cmp_cnt - ONE_L_C;
          if (oob && WRAP == 0) begin
            state_d     = S_DEAD;
            step_done_d = 1'b1;
          end else if (cmp_cnt == '0) begin
            state_d = S_MOVE;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (hit) begin
          state_d     = S_DEAD;
          step_done_d = 1'b1;
        end else if (idx_q == last_q) begin
          state_d = S_MOVE;
        end else begin
          idx_d = idx_q + ONE_L_C;
        end
      end
      S_MOVE: begin
        if (grow_q) begin
          length_d = length_q + ONE_L_C;
        end
        step_done_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_DEAD;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dir_q       <= DIR_E;
      grow_q      <= 1'b0;
      cand_x_q    <= '0;
      cand_y_q    <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      length_q    <= LEN_WIDTH'(INIT_LEN);
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      grow_q      <= grow_d;
      cand_x_q    <= cand_x_d;
      cand_y_q    <= cand_y_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      length_q    <= length_d;
      step_done_q <= step_done_d;
    end
  end

  // Segment shift register: initial horizontal body, shifted by one on each committed move
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          seg_x_q[i] <= ADDR_WIDTH'(BOARD_WIDTH / 2 - i);
          seg_y_q[i] <= ADDR_WIDTH'(BOARD_HEIGHT / 2);
        end else begin
          seg_x_q[i] <= '0;
          seg_y_q[i] <= '0;
        end
      end
    end else if (state_q == S_MOVE) begin
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_q[i] <= seg_x_q[i-1];
        seg_y_q[i] <= seg_y_q[i-1];
      end
      seg_x_q[0] <= cand_x_q;
      seg_y_q[0] <= cand_y_q;
    end
  end

  assign bus.busy_o      = (state_q == S_CHECK) || (state_q == S_MOVE);
  assign bus.step_done_o = step_done_q;
  assign bus.alive_o     = (state_q != S_DEAD);
  assign bus.head_x_o    = seg_x_q[0];
  assign bus.head_y_o    = seg_y_q[0];
  assign bus.length_o    = length_q;
  assign bus.rd_x_o      = rd_x;
  assign bus.rd_y_o      = rd_y;
  assign bus.rd_valid_o  = rd_ok;

endmodule

// File: tb/tb_snake_body_engine.sv
// tb/tb_snake_body_engine.sv - directed table-driven bench for snake_body_engine
module tb_snake_body_engine;

  localparam logic [1:0] N = 2'b00, E = 2'b01, S = 2'b10, W = 2'b11;

  typedef struct {
    logic [1:0] dir;
    logic       grow;
    int         exp_x;
    int         exp_y;
    int         exp_len;
    int         exp_lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       step = 1'b0;
  logic [1:0] dir = E;
  logic       grow = 1'b0;
  logic [5:0] rd_idx = '0;
  int         sel = 0;

  int tests_run = 0;
  int tests_failed = 0;

  vec_t tbl [17];

  snake_body_engine_if #(.ADDR_WIDTH(5), .LEN_WIDTH(6)) if_main ();
  snake_body_engine_if #(.ADDR_WIDTH(5), .LEN_WIDTH(6)) if_w0 ();
  snake_body_engine_if #(.ADDR_WIDTH(5), .LEN_WIDTH(6)) if_m4 ();

  snake_body_engine u_main (.clk(clk), .reset_n(reset_n), .bus(if_main.slave));
  snake_body_engine #(.WRAP(0)) u_w0 (.clk(clk), .reset_n(reset_n), .bus(if_w0.slave));
  snake_body_engine #(.MAX_LEN(4)) u_m4 (.clk(clk), .reset_n(reset_n), .bus(if_m4.slave));

  assign if_main.step_i = step && (sel == 0);
  assign if_w0.step_i   = step && (sel == 1);
  assign if_m4.step_i   = step && (sel == 2);
  assign if_main.direction_i = dir;
  assign if_w0.direction_i   = dir;
  assign if_m4.direction_i   = dir;
  assign if_main.grow_i = grow;
  assign if_w0.grow_i   = grow;
  assign if_m4.grow_i   = grow;
  assign if_main.rd_idx_i = rd_idx;
  assign if_w0.rd_idx_i   = rd_idx;
  assign if_m4.rd_idx_i   = rd_idx;

  logic       o_busy, o_done, o_alive, o_rdv;
  logic [4:0] o_hx, o_hy, o_rx, o_ry;
  logic [5:0] o_len;

  assign o_busy  = (sel == 0) ? if_main.busy_o      : (sel == 1) ? if_w0.busy_o      : if_m4.busy_o;
  assign o_done  = (sel == 0) ? if_main.step_done_o : (sel == 1) ? if_w0.step_done_o : if_m4.step_done_o;
  assign o_alive = (sel == 0) ? if_main.alive_o     : (sel == 1) ? if_w0.alive_o     : if_m4.alive_o;
  assign o_rdv   = (sel == 0) ? if_main.rd_valid_o  : (sel == 1) ? if_w0.rd_valid_o  : if_m4.rd_valid_o;
  assign o_hx    = (sel == 0) ? if_main.head_x_o    : (sel == 1) ? if_w0.head_x_o    : if_m4.head_x_o;
  assign o_hy    = (sel == 0) ? if_main.head_y_o    : (sel == 1) ? if_w0.head_y_o    : if_m4.head_y_o;
  assign o_rx    = (sel == 0) ? if_main.rd_x_o      : (sel == 1) ? if_w0.rd_x_o      : if_m4.rd_x_o;
  assign o_ry    = (sel == 0) ? if_main.rd_y_o      : (sel == 1) ? if_w0.rd_y_o      : if_m4.rd_y_o;
  assign o_len   = (sel == 0) ? if_main.length_o    : (sel == 1) ? if_w0.length_o    : if_m4.length_o;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [1:0] d, input logic g,
                         input int x, input int y, input int len, input int lat);
    tbl[i].dir = d;
    tbl[i].grow = g;
    tbl[i].exp_x = x;
    tbl[i].exp_y = y;
    tbl[i].exp_len = len;
    tbl[i].exp_lat = lat;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Issue one step; lat = edges after the acceptance edge until step_done is seen
  task automatic do_step(input logic [1:0] d, input logic g, input logic poke,
                         output int lat, output int busy_e0);
    @(negedge clk);
    dir = d;
    grow = g;
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
    busy_e0 = int'(o_busy);
    if (poke) step = 1'b1;
    lat = 0;
    while (!o_done && lat < 100) begin
      @(posedge clk);
      #1;
      step = 1'b0;
      lat++;
    end
    step = 1'b0;
    grow = 1'b0;
  endtask

  task automatic no_done(input string name, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (o_done) seen++;
    end
    chk(name, seen, 0);
  endtask

  task automatic rd_chk(input string name, input int idx, input int ev, input int ex, input int ey);
    rd_idx = 6'(idx);
    #1;
    chk({name, "_valid"}, int'(o_rdv), ev);
    chk({name, "_x"}, int'(o_rx), ex);
    chk({name, "_y"}, int'(o_ry), ey);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b0;

    // Main DUT walk from reset: reversal, turns, growth, west wrap, east wrap, tail-cell reuse
    set_vec(0,  W, 1'b0, 11, 10, 3, 3);
    set_vec(1,  N, 1'b0, 11,  9, 3, 3);
    set_vec(2,  W, 1'b0, 10,  9, 3, 3);
    set_vec(3,  E, 1'b0,  9,  9, 3, 3);
    set_vec(4,  W, 1'b1,  8,  9, 4, 4);
    for (int i = 5; i <= 12; i++) set_vec(i, W, 1'b0, 12 - i, 9, 4, 4);
    set_vec(13, W, 1'b0, 19,  9, 4, 4);
    set_vec(14, S, 1'b0, 19, 10, 4, 4);
    set_vec(15, E, 1'b0,  0, 10, 4, 4);
    set_vec(16, N, 1'b0,  0,  9, 4, 4);

    sel = 0;
    do_reset();
    #1;
    chk("rst_head_x", int'(o_hx), 10);
    chk("rst_head_y", int'(o_hy), 10);
    chk("rst_len", int'(o_len), 3);
    chk("rst_alive", int'(o_alive), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    rd_chk("rst_seg1", 1, 1, 9, 10);
    rd_chk("rst_seg2", 2, 1, 8, 10);
    rd_chk("rst_seg3", 3, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      do_step(tbl[i].dir, tbl[i].grow, 1'b1, lat, b0);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("vec%0d_busy_e0", i), b0, 1);
      chk($sformatf("vec%0d_x", i), int'(o_hx), tbl[i].exp_x);
      chk($sformatf("vec%0d_y", i), int'(o_hy), tbl[i].exp_y);
      chk($sformatf("vec%0d_len", i), int'(o_len), tbl[i].exp_len);
      chk($sformatf("vec%0d_alive", i), int'(o_alive), 1);
      chk($sformatf("vec%0d_busy_end", i), int'(o_busy), 0);
    end
    no_done("main_no_queued_step", 5);
    chk("main_head_stable", int'(o_hx), 0);
    rd_chk("main_seg1", 1, 1, 0, 10);
    rd_chk("main_seg3", 3, 1, 19, 9);
    rd_chk("main_seg4", 4, 0, 0, 0);

    // Growth then self collision with seg3 at compare 3
    do_reset();
    do_step(E, 1'b1, 1'b0, lat, b0);
    chk("grow1_lat", lat, 4);
    chk("grow1_len", int'(o_len), 4);
    do_step(E, 1'b1, 1'b0, lat, b0);
    chk("grow2_lat", lat, 5);
    chk("grow2_len", int'(o_len), 5);
    chk("grow2_x", int'(o_hx), 12);
    do_step(S, 1'b0, 1'b0, lat, b0);
    chk("turn_s_y", int'(o_hy), 11);
    do_step(W, 1'b0, 1'b0, lat, b0);
    chk("turn_w_x", int'(o_hx), 11);
    do_step(N, 1'b0, 1'b0, lat, b0);
    chk("hit_lat", lat, 4);
    chk("hit_busy_e0", b0, 1);
    chk("hit_alive", int'(o_alive), 0);
    chk("hit_len", int'(o_len), 5);
    chk("hit_x", int'(o_hx), 11);
    chk("hit_y", int'(o_hy), 11);
    chk("hit_busy", int'(o_busy), 0);
    rd_chk("hit_seg3", 3, 1, 11, 10);
    @(negedge clk); step = 1'b1; dir = E;
    @(negedge clk); step = 1'b0;
    no_done("dead_ignore", 5);
    chk("dead_x", int'(o_hx), 11);

    // WRAP=0: walk to x=0 then leave the board westward
    sel = 1;
    do_step(N, 1'b0, 1'b0, lat, b0);
    chk("w0_n_y", int'(o_hy), 9);
    for (int i = 0; i < 10; i++) begin
      do_step(W, 1'b0, 1'b0, lat, b0);
      chk($sformatf("w0_walk%0d_x", i), int'(o_hx), 9 - i);
    end
    do_step(W, 1'b0, 1'b0, lat, b0);
    chk("w0_wall_lat", lat, 0);
    chk("w0_wall_busy_e0", b0, 0);
    chk("w0_wall_alive", int'(o_alive), 0);
    chk("w0_wall_x", int'(o_hx), 0);
    chk("w0_wall_y", int'(o_hy), 9);
    chk("w0_wall_len", int'(o_len), 3);
    rd_chk("w0_seg2", 2, 1, 2, 9);
    @(negedge clk); step = 1'b1; dir = S;
    @(negedge clk); step = 1'b0;
    no_done("w0_dead_ignore", 5);
    chk("w0_dead_y", int'(o_hy), 9);

    // MAX_LEN=4: length saturates under repeated growth
    sel = 2;
    for (int i = 0; i < 3; i++) begin
      do_step(E, 1'b1, 1'b0, lat, b0);
      chk($sformatf("m4_grow%0d_lat", i), lat, 4);
      chk($sformatf("m4_grow%0d_len", i), int'(o_len), 4);
      chk($sformatf("m4_grow%0d_x", i), int'(o_hx), 11 + i);
    end
    rd_chk("m4_seg3", 3, 1, 10, 10);
    rd_chk("m4_seg4", 4, 0, 0, 0);

    // Reset asserted mid-CHECK
    rd_idx = 6'd2;
    @(negedge clk); dir = E; step = 1'b1;
    @(posedge clk); #1; step = 1'b0;
    chk("midchk_busy_e0", int'(o_busy), 1);
    @(posedge clk); #1;
    chk("midchk_busy_e1", int'(o_busy), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_x", int'(o_hx), 10);
    chk("midrst_y", int'(o_hy), 10);
    chk("midrst_len", int'(o_len), 3);
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_alive", int'(o_alive), 1);
    chk("midrst_done", int'(o_done), 0);
    chk("midrst_seg2_x", int'(o_rx), 8);
    @(negedge clk); reset_n = 1'b1;
    no_done("midrst_no_done", 6);
    chk("midrst_after_x", int'(o_hx), 10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
